acc_shared_port_arbiter: RTL



---
 rtl/acc_shared_port_arbiter_pkg.sv | 20 ++
 rtl/acc_owner_fifo.sv | 76 +++++++
 rtl/acc_shared_port_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/acc_shared_port_arbiter_pkg.sv
// ------------------------------------------------------------------
// acc_shared_port_arbiter_pkg : width helpers for the shared-port arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package acc_shared_port_arbiter_pkg;

    // Index width never collapses to zero, even for a single entry.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/acc_owner_fifo.sv
// ------------------------------------------------------------------
// acc_owner_fifo : in-order FIFO of requester indices
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module acc_owner_fifo
    import acc_shared_port_arbiter_pkg::*;
#(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            push_i,
    input  logic [Width-1:0]                data_i,
    input  logic                            pop_i,
    output logic [Width-1:0]                data_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [cnt_width(Depth)-1:0]     usage_o
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = cnt_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  usage_q, usage_d;

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (usage_q == CntW'(Depth));
    assign empty_o = (usage_q == '0);
    assign usage_o = usage_q;

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (push_i && !pop_i) begin
            usage_d = usage_q + CntW'(1);
        end else if (pop_i && !push_i) begin
            usage_d = usage_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/acc_shared_port_arbiter.sv
// ------------------------------------------------------------------
// acc_shared_port_arbiter : round-robin sharing of one accelerator port
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module acc_shared_port_arbiter
    import acc_shared_port_arbiter_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         acc_c_req_chan_t = logic,
    parameter type         acc_c_rsp_chan_t = logic
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  acc_c_req_chan_t [NumReq-1:0]            slv_q_i,
    input  logic [NumReq-1:0]                       slv_q_valid_i,
    output logic [NumReq-1:0]                       slv_q_ready_o,
    output acc_c_rsp_chan_t [NumReq-1:0]            slv_p_o,
    output logic [NumReq-1:0]                       slv_p_valid_o,
    input  logic [NumReq-1:0]                       slv_p_ready_i,
    output acc_c_req_chan_t                         mst_q_o,
    output logic                                    mst_q_valid_o,
    input  logic                                    mst_q_ready_i,
    input  acc_c_rsp_chan_t                         mst_p_i,
    input  logic                                    mst_p_valid_i,
    output logic                                    mst_p_ready_o,
    output logic [cnt_width(MaxOutstanding)-1:0]    outstanding_o
);

    localparam int unsigned IdxW = idx_width(NumReq);

    logic [IdxW-1:0] rr_q, rr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;

    logic            hi_found, lo_found;
    logic [IdxW-1:0] hi_idx, lo_idx;
    logic            gnt_valid;
    logic [IdxW-1:0] gnt_idx;
    logic            q_hs, p_hs;
    logic            fifo_full, fifo_empty;
    logic [IdxW-1:0] head_idx;

    // Round robin: lowest valid index at or above rr_q, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (slv_q_valid_i[i]) begin
                if (IdxW'(i) >= rr_q) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = IdxW'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IdxW'(i);
                end
            end
        end
    end

    always_comb begin
        if (lock_q) begin
            gnt_idx   = lock_idx_q;
            gnt_valid = slv_q_valid_i[lock_idx_q];
        end else begin
            gnt_idx   = hi_found ? hi_idx : lo_idx;
            gnt_valid = hi_found | lo_found;
        end
    end

    // Issue is blocked purely on the registered count: no p-to-q path.
    always_comb begin
        mst_q_valid_o = gnt_valid & ~fifo_full;
        mst_q_o       = '0;
        if (gnt_valid) begin
            mst_q_o = slv_q_i[gnt_idx];
        end
        slv_q_ready_o = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            slv_q_ready_o[i] = mst_q_ready_i & ~fifo_full & gnt_valid & (gnt_idx == IdxW'(i));
        end
    end

    assign q_hs = mst_q_valid_o & mst_q_ready_i;

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (q_hs) begin
            rr_d   = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
            lock_d = 1'b0;
        end else if (mst_q_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_comb begin
        mst_p_ready_o = ~fifo_empty & slv_p_ready_i[head_idx];
        slv_p_valid_o = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            slv_p_o[i]       = mst_p_i;
            slv_p_valid_o[i] = ~fifo_empty & mst_p_valid_i & (head_idx == IdxW'(i));
        end
    end

    assign p_hs = mst_p_valid_i & mst_p_ready_o;

    acc_owner_fifo #(
        .Width (IdxW),
        .Depth (MaxOutstanding)
    ) i_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (q_hs),
        .data_i  (gnt_idx),
        .pop_i   (p_hs),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (outstanding_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(mst_p_valid_i && fifo_empty))
                else $error("acc_shared_port_arbiter: response with no outstanding request");
        end
    end

endmodule

`default_nettype wire
